// File: rtl/qlen_cnt_pkg.sv
// Shared types and helpers for the hierarchical queue-length counter.
// Packed din/dout structs are built in the module from these widths.
package qlen_cnt_pkg;

  localparam int MAX_LVL = 16;

  typedef logic [MAX_LVL-1:0] eot_vec_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // AND of the lowest lvl eot bits; an empty range (lvl == 0) is true.
  function automatic logic eot_all(input eot_vec_t eot, input int lvl);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_LVL; i++) begin
      if (i < lvl) r = r & eot[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/qlen_cnt_hier_if.sv
// Valid/ready stream bundle: producer drives valid/data, consumer drives ready.
interface qlen_cnt_hier_if #(
  parameter int W = 18
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/dti_out_reg.sv
// One-entry output buffer: load sets FULL next cycle, unload on ready_i empties it.
// Data is held while FULL and not unloaded; a simultaneous unload+load reloads.
module dti_out_reg
  import qlen_cnt_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  out_state_e   state_q, state_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = load_i ? data_i : data_q;
    unique case (state_q)
      OUT_EMPTY: if (load_i) state_d = OUT_FULL;
      OUT_FULL:  if (ready_i && !load_i) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    valid_o = (state_q == OUT_FULL);
    data_o  = data_q;
  end

endmodule

// File: rtl/qlen_cnt_hier.sv
// Counts completed level-CNT_LVL groups per level-OUT_LVL group; count registered, 1 cycle latency.
// Only a closing element stalls, and only while the output buffer is full and dout is not ready.
module qlen_cnt_hier
  import qlen_cnt_pkg::*;
#(
  parameter int TDIN      = 16,
  parameter int DIN_LVL   = 2,
  parameter int CNT_LVL   = 1,
  parameter int OUT_LVL   = DIN_LVL,
  parameter int W_OUT     = 16,
  parameter int INCLUSIVE = 1,
  parameter int SATURATE  = 1
) (
  input logic                clk,
  input logic                rst,
  qlen_cnt_hier_if.consumer  din,
  qlen_cnt_hier_if.producer  dout
);

  localparam int W_UP   = DIN_LVL - OUT_LVL;
  localparam int W_DOUT = W_UP + 1 + W_OUT;

  if (!(CNT_LVL >= 0 && CNT_LVL <= OUT_LVL && OUT_LVL <= DIN_LVL &&
        DIN_LVL >= 1 && DIN_LVL <= MAX_LVL && W_OUT >= 1)) begin : g_bad_params
    $error("qlen_cnt_hier: illegal level/width parameters");
  end

  typedef struct packed {
    logic [DIN_LVL-1:0] eot;
    logic [TDIN-1:0]    dat;
  } din_t;

  din_t              din_s;
  eot_vec_t          eot_ext;
  logic              part_last, out_last, acc, close, out_vld, unused_dat;
  logic [W_OUT:0]    sum_w;
  logic [W_OUT-1:0]  cnt_q, cnt_d, cnt_nxt, res_cnt;
  logic              ovf_q, ovf_d, ovf_nxt, res_ovf;
  logic [W_DOUT-1:0] out_dat;

  assign din_s      = din.data;
  assign unused_dat = ^din_s.dat;
  assign eot_ext    = eot_vec_t'(din_s.eot);
  assign part_last  = eot_all(eot_ext, CNT_LVL);
  assign out_last   = eot_all(eot_ext, OUT_LVL);

  assign din.ready = !out_last || !out_vld || dout.ready;
  assign acc       = din.valid && din.ready;
  assign close     = acc && out_last;

  // Carry out of the running add marks overflow; saturate or let it wrap.
  assign sum_w   = {1'b0, cnt_q} + (W_OUT+1)'(part_last);
  assign cnt_nxt = sum_w[W_OUT] ? ((SATURATE != 0) ? '1 : '0) : sum_w[W_OUT-1:0];
  assign ovf_nxt = ovf_q | sum_w[W_OUT];

  assign res_cnt = (INCLUSIVE != 0) ? cnt_nxt : cnt_q;
  assign res_ovf = (INCLUSIVE != 0) ? ovf_nxt : ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (acc) begin
      if (out_last) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        cnt_d = cnt_nxt;
        ovf_d = ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  if (W_UP > 0) begin : g_up_eot
    assign out_dat = {din_s.eot[DIN_LVL-1:OUT_LVL], res_ovf, res_cnt};
  end else begin : g_no_up_eot
    assign out_dat = {res_ovf, res_cnt};
  end

  dti_out_reg #(
    .W (W_DOUT)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (close),
    .data_i  (out_dat),
    .ready_i (dout.ready),
    .valid_o (out_vld),
    .data_o  (dout.data)
  );

  assign dout.valid = out_vld;

endmodule

// File: tb/tb_qlen_cnt_hier.sv
// Five differently-parameterised counters driven side by side, checked against
// directed constants and a group-counting reference model.
module tb_qlen_cnt_hier;

  localparam int N = 5;

  function automatic int cfg_din(int g);
    int r; r = 2;
    if (g == 2) r = 3;
    if (g >= 3) r = 1;
    return r;
  endfunction
  function automatic int cfg_cnt(int g);
    int r; r = (g <= 1) ? 1 : 0;
    return r;
  endfunction
  function automatic int cfg_out(int g);
    int r; r = (g <= 1) ? 2 : 1;
    return r;
  endfunction
  function automatic int cfg_td(int g);
    int r; r = (g == 2) ? 8 : 16;
    return r;
  endfunction
  function automatic int cfg_w(int g);
    int r; r = (g >= 3) ? 3 : 16;
    return r;
  endfunction
  function automatic int cfg_incl(int g);
    int r; r = (g == 1) ? 0 : 1;
    return r;
  endfunction
  function automatic int cfg_sat(int g);
    int r; r = (g == 4) ? 0 : 1;
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] vld, rdy;
  logic [2:0]   eot  [N];
  logic [15:0]  ddat [N];
  wire  [N-1:0] o_vld, o_rdyin, o_ovf;
  wire  [15:0]  o_cnt [N];
  wire  [1:0]   o_eot [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DL  = cfg_din(g);
    localparam int CL  = cfg_cnt(g);
    localparam int OL  = cfg_out(g);
    localparam int TD  = cfg_td(g);
    localparam int WO  = cfg_w(g);
    localparam int WOU = DL - OL + 1 + WO;

    qlen_cnt_hier_if #(.W(DL + TD)) din_if ();
    qlen_cnt_hier_if #(.W(WOU))     dout_if ();

    assign din_if.valid  = vld[g];
    assign din_if.data   = {eot[g][DL-1:0], ddat[g][TD-1:0]};
    assign dout_if.ready = rdy[g];
    assign o_rdyin[g]    = din_if.ready;
    assign o_vld[g]      = dout_if.valid;
    assign o_cnt[g]      = 16'(dout_if.data[WO-1:0]);
    assign o_ovf[g]      = dout_if.data[WO];
    if (OL < DL) begin : g_e
      assign o_eot[g] = 2'(dout_if.data[WOU-1:WO+1]);
    end else begin : g_ne
      assign o_eot[g] = 2'b00;
    end

    qlen_cnt_hier #(
      .TDIN(TD), .DIN_LVL(DL), .CNT_LVL(CL), .OUT_LVL(OL), .W_OUT(WO),
      .INCLUSIVE(cfg_incl(g)), .SATURATE(cfg_sat(g))
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din_if),
      .dout (dout_if)
    );
  end

  typedef struct packed {
    logic [15:0] cnt;
    logic        ovf;
    logic [1:0]  eot;
  } out_t;

  out_t exp_q [N][$];
  out_t obs_q [N][$];
  int   grp [N];
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic logic low_all(logic [2:0] e, int lvl);
    int mask;
    mask = (1 << lvl) - 1;
    return ((int'(e) & mask) == mask);
  endfunction

  // Reference: count true groups as an unbounded integer, then apply width rules.
  task automatic model_accept(int g, logic [2:0] e);
    int   n, maxv;
    out_t o;
    if (low_all(e, cfg_cnt(g))) grp[g]++;
    if (low_all(e, cfg_out(g))) begin
      n    = (cfg_incl(g) != 0) ? grp[g] : grp[g] - 1;
      maxv = (1 << cfg_w(g)) - 1;
      o.ovf = (n > maxv);
      if (n > maxv && cfg_sat(g) != 0) o.cnt = 16'(maxv);
      else                             o.cnt = 16'(n % (maxv + 1));
      o.eot = 2'(int'(e) >> cfg_out(g));
      exp_q[g].push_back(o);
      grp[g] = 0;
    end
  endtask

  task automatic step();
    #1;
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        grp[g] = 0;
        while (exp_q[g].size() > obs_q[g].size()) void'(exp_q[g].pop_back());
      end else begin
        if (vld[g] && o_rdyin[g]) model_accept(g, eot[g]);
        if (o_vld[g] && rdy[g]) obs_q[g].push_back(out_t'{o_cnt[g], o_ovf[g], o_eot[g]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(int g, logic v, logic [2:0] e);
    vld[g]  = v;
    eot[g]  = e;
    ddat[g] = 16'($urandom);
  endtask

  task automatic clear_q();
    for (int g = 0; g < N; g++) begin
      exp_q[g].delete();
      obs_q[g].delete();
      grp[g] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; rdy = '0;
    for (int g = 0; g < N; g++) drive(g, 1'b0, 3'd0);
    step(); step();
    for (int g = 0; g < N; g++) begin
      n_chk++; if (o_vld[g] !== 1'b0) $display("FAIL reset_vld[%0d]: got %b want 0", g, o_vld[g]); else n_pass++;
      n_chk++; if (o_cnt[g] !== 16'd0) $display("FAIL reset_cnt[%0d]: got %0d want 0", g, o_cnt[g]); else n_pass++;
      n_chk++; if (o_ovf[g] !== 1'b0) $display("FAIL reset_ovf[%0d]: got %b want 0", g, o_ovf[g]); else n_pass++;
    end
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_basic_stream();
    logic [2:0] seq [6];
    seq = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd3};
    rdy = '1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, seq[i]);
      drive(1, 1'b1, seq[i]);
      step();
      if (i == 4) begin
        n_chk++; if (o_vld[0] !== 1'b0) $display("FAIL basic_early_vld: got %b want 0", o_vld[0]); else n_pass++;
      end
    end
    n_chk++; if (o_vld[0] !== 1'b1) $display("FAIL basic_vld: got %b want 1", o_vld[0]); else n_pass++;
    n_chk++; if ({o_ovf[0], o_cnt[0]} !== {1'b0, 16'd3}) $display("FAIL basic_incl: got cnt %0d ovf %b want 3/0", o_cnt[0], o_ovf[0]); else n_pass++;
    n_chk++; if ({o_vld[1], o_cnt[1]} !== {1'b1, 16'd2}) $display("FAIL basic_excl: got vld %b cnt %0d want 1/2", o_vld[1], o_cnt[1]); else n_pass++;
    vld = '0;
    step();
    n_chk++; if (o_vld[0] !== 1'b0) $display("FAIL basic_single_out: got %b want 0", o_vld[0]); else n_pass++;
    clear_q();
  endtask

  task automatic test_groups();
    logic [2:0] seq [7];
    seq = '{3'd0, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd7};
    rdy = '1;
    for (int i = 0; i < 7; i++) begin
      drive(2, 1'b1, seq[i]);
      step();
      if (i == 1) begin
        n_chk++; if ({o_vld[2], o_cnt[2], o_eot[2]} !== {1'b1, 16'd2, 2'b10}) $display("FAIL grp1: got vld %b cnt %0d eot %b want 1/2/10", o_vld[2], o_cnt[2], o_eot[2]); else n_pass++;
      end
      if (i == 2) begin
        n_chk++; if ({o_vld[2], o_cnt[2], o_eot[2]} !== {1'b1, 16'd1, 2'b10}) $display("FAIL grp2: got vld %b cnt %0d eot %b want 1/1/10", o_vld[2], o_cnt[2], o_eot[2]); else n_pass++;
      end
      if (i == 6) begin
        n_chk++; if ({o_vld[2], o_cnt[2], o_eot[2]} !== {1'b1, 16'd4, 2'b11}) $display("FAIL grp3: got vld %b cnt %0d eot %b want 1/4/11", o_vld[2], o_cnt[2], o_eot[2]); else n_pass++;
      end
    end
    vld = '0;
    step();
    clear_q();
  endtask

  task automatic test_backpressure();
    int sent;
    sent = 0;
    vld = '0;
    for (int c = 0; c < 12; c++) begin
      rdy[0] = (c >= 5);
      drive(0, (sent < 3), 3'd3);
      #1;
      if (c >= 1 && c <= 4) begin
        n_chk++; if (o_rdyin[0] !== 1'b0) $display("FAIL bp_din_ready c%0d: got %b want 0", c, o_rdyin[0]); else n_pass++;
        n_chk++; if ({o_vld[0], o_cnt[0]} !== {1'b1, 16'd1}) $display("FAIL bp_hold c%0d: got vld %b cnt %0d want 1/1", c, o_vld[0], o_cnt[0]); else n_pass++;
      end
      if (vld[0] && o_rdyin[0]) sent++;
      step();
    end
    vld = '0;
    n_chk++; if (sent != 3) $display("FAIL bp_sent: got %0d want 3", sent); else n_pass++;
    n_chk++; if (obs_q[0].size() != 3) $display("FAIL bp_count: got %0d want 3", obs_q[0].size()); else n_pass++;
    foreach (obs_q[0][k]) begin
      n_chk++; if (obs_q[0][k] !== out_t'{16'd1, 1'b0, 2'b00}) $display("FAIL bp_val[%0d]: got cnt %0d ovf %b want 1/0", k, obs_q[0][k].cnt, obs_q[0][k].ovf); else n_pass++;
    end
    rdy = '1;
    clear_q();
  endtask

  task automatic test_saturate();
    rdy = '1;
    for (int i = 0; i < 12; i++) begin
      drive(3, 1'b1, (i == 9 || i == 11) ? 3'd1 : 3'd0);
      drive(4, 1'b1, (i == 9 || i == 11) ? 3'd1 : 3'd0);
      step();
      if (i == 9) begin
        n_chk++; if ({o_vld[3], o_ovf[3], o_cnt[3]} !== {2'b11, 16'd7}) $display("FAIL sat_cnt: got vld %b cnt %0d ovf %b want 1/7/1", o_vld[3], o_cnt[3], o_ovf[3]); else n_pass++;
        n_chk++; if ({o_vld[4], o_ovf[4], o_cnt[4]} !== {2'b11, 16'd2}) $display("FAIL wrap_cnt: got vld %b cnt %0d ovf %b want 1/2/1", o_vld[4], o_cnt[4], o_ovf[4]); else n_pass++;
      end
      if (i == 11) begin
        n_chk++; if ({o_vld[3], o_ovf[3], o_cnt[3]} !== {2'b10, 16'd2}) $display("FAIL sat_next: got vld %b cnt %0d ovf %b want 1/2/0", o_vld[3], o_cnt[3], o_ovf[3]); else n_pass++;
        n_chk++; if ({o_vld[4], o_ovf[4], o_cnt[4]} !== {2'b10, 16'd2}) $display("FAIL wrap_next: got vld %b cnt %0d ovf %b want 1/2/0", o_vld[4], o_cnt[4], o_ovf[4]); else n_pass++;
      end
    end
    vld = '0;
    step();
    clear_q();
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre [3];
    pre = '{3'd0, 3'd1, 3'd0};
    rdy = '1;
    for (int i = 0; i < 3; i++) begin drive(0, 1'b1, pre[i]); step(); end
    vld = '0; rst = 1'b1; step(); rst = 1'b0;
    n_chk++; if (o_vld[0] !== 1'b0) $display("FAIL rst_mid_vld: got %b want 0", o_vld[0]); else n_pass++;
    drive(0, 1'b1, 3'd1); step();
    drive(0, 1'b1, 3'd3); step();
    n_chk++; if ({o_vld[0], o_cnt[0]} !== {1'b1, 16'd2}) $display("FAIL rst_mid_cnt: got vld %b cnt %0d want 1/2", o_vld[0], o_cnt[0]); else n_pass++;
    vld = '0; rdy[0] = 1'b0; step();
    n_chk++; if (o_vld[0] !== 1'b1) $display("FAIL rst_full_held: got %b want 1", o_vld[0]); else n_pass++;
    rst = 1'b1; step(); rst = 1'b0;
    n_chk++; if (o_vld[0] !== 1'b0) $display("FAIL rst_full_vld: got %b want 0", o_vld[0]); else n_pass++;
    rdy = '1;
    drive(0, 1'b1, 3'd1); step();
    drive(0, 1'b1, 3'd3); step();
    n_chk++; if ({o_vld[0], o_cnt[0]} !== {1'b1, 16'd2}) $display("FAIL rst_full_cnt: got vld %b cnt %0d want 1/2", o_vld[0], o_cnt[0]); else n_pass++;
    vld = '0; step();
    clear_q();
  endtask

  task automatic test_random();
    logic hold [N];
    out_t prev [N];
    out_t cur, e, o;
    logic exp_rdy;
    for (int g = 0; g < N; g++) hold[g] = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int g = 0; g < N; g++) begin
        if (g >= 3) drive(g, ($urandom % 4) != 0, 3'($urandom_range(0, 9) == 0));
        else        drive(g, ($urandom % 4) != 0, 3'($urandom_range(0, (1 << cfg_din(g)) - 1)));
        rdy[g] = ($urandom % 3) != 0;
      end
      #1;
      for (int g = 0; g < N; g++) begin
        cur = out_t'{o_cnt[g], o_ovf[g], o_eot[g]};
        exp_rdy = !low_all(eot[g], cfg_out(g)) || !o_vld[g] || rdy[g];
        n_chk++; if (o_rdyin[g] !== exp_rdy) $display("FAIL rnd_din_ready[%0d] cyc %0d: got %b want %b", g, cyc, o_rdyin[g], exp_rdy); else n_pass++;
        if (hold[g]) begin
          n_chk++;
          if (o_vld[g] !== 1'b1 || cur !== prev[g]) $display("FAIL rnd_stable[%0d] cyc %0d: got vld %b data %h want 1/%h", g, cyc, o_vld[g], cur, prev[g]);
          else n_pass++;
        end
        hold[g] = o_vld[g] && !rdy[g];
        prev[g] = cur;
      end
      step();
    end
    vld = '0; rdy = '1;
    step(); step(); step();
    for (int g = 0; g < N; g++) begin
      n_chk++; if (obs_q[g].size() != exp_q[g].size()) $display("FAIL rnd_count[%0d]: got %0d want %0d", g, obs_q[g].size(), exp_q[g].size()); else n_pass++;
      while (obs_q[g].size() > 0 && exp_q[g].size() > 0) begin
        o = obs_q[g].pop_front();
        e = exp_q[g].pop_front();
        n_chk++;
        if (o !== e) $display("FAIL rnd_out[%0d]: got cnt %0d ovf %b eot %b want cnt %0d ovf %b eot %b", g, o.cnt, o.ovf, o.eot, e.cnt, e.ovf, e.eot);
        else n_pass++;
      end
    end
    clear_q();
  endtask

  initial begin
    vld = '0;
    rdy = '0;
    for (int g = 0; g < N; g++) begin
      eot[g] = 3'd0; ddat[g] = 16'd0; grp[g] = 0;
    end
    test_reset();
    test_basic_stream();
    test_groups();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qlen_cnt_hier.md
# qlen_cnt_hier

Hierarchical queue-length counter for eot-tagged DTI streams. It consumes a queue of depth `DIN_LVL` and counts completed level-`CNT_LVL` sub-groups inside each level-`OUT_LVL` group. It emits one count per level-`OUT_LVL` group as a new queue that carries the remaining upper eot bits. It sits after any queue-producing stage (flatten, serialize, filter) where downstream logic needs group sizes, such as length-prefixed packers and reducers. It adds a registered output stage, saturation and an overflow flag.

## Interface
- `TDIN`, 16: data field width of din (ignored, counted only).
- `DIN_LVL`, 2: number of eot bits on din, ≥1.
- `CNT_LVL`, 1: level being counted, 0..`OUT_LVL`. 0 means every element is counted.
- `OUT_LVL`, `DIN_LVL`: level at which a count is emitted, `CNT_LVL`..`DIN_LVL`.
- `W_OUT`, 16: counter width.
- `INCLUSIVE`, 1: 1 emits the number of groups; 0 emits the number of groups minus 1.
- `SATURATE`, 1: 1 holds the count at all-ones on overflow; 0 wraps the count modulo 2^`W_OUT`.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `din` dti.consumer `DIN_LVL`+`TDIN`: packed {eot[`DIN_LVL`-1:0], data[`TDIN`-1:0]}.
- `dout` dti.producer `DIN_LVL`-`OUT_LVL`+1+`W_OUT`: packed {eot[`DIN_LVL`-`OUT_LVL`-1:0], ovf, cnt[`W_OUT`-1:0]}. The eot field is absent when `OUT_LVL`==`DIN_LVL`.

## Operation
- `part_last` = &eot[`CNT_LVL`-1:0]. It is constant 1 when `CNT_LVL`=0.
- `out_last` = &eot[`OUT_LVL`-1:0].
- `inc` = `part_last` on every accepted element.
- On an accepted element with `out_last`=0: `cnt_reg` ← `cnt_reg`+`inc`. No output is produced.
- On an accepted element with `out_last`=1:
  - The output register loads `cnt` = `cnt_reg`+1-(`INCLUSIVE`?0:1), `ovf` = `ovf_reg` or the final add overflowed, and `eot` = din eot[`DIN_LVL`-1:`OUT_LVL`].
  - `cnt_reg` and `ovf_reg` clear to 0.
  - `out_last` implies `part_last`, so the closing element always completes a group.
- Overflow (`cnt_reg` all-ones and `inc`=1):
  - If `SATURATE`: the count holds at all-ones.
  - Otherwise: the count wraps to 0.
  - In both cases `ovf_reg` is set and stays set until the group closes.
- `INCLUSIVE`=0 on a saturated count emits all-ones minus 1 only if the count did not saturate. A saturated count emits all-ones with `ovf`=1.
- States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1), the one-entry output buffer.
  - EMPTY→FULL on an accepted `out_last` element.
  - FULL→EMPTY on a dout handshake with no new `out_last` accept.
  - FULL→FULL on a dout handshake with a simultaneous `out_last` accept. The register reloads with the new count.
- `din.ready` = !`out_last` || !`out_valid` || `dout.ready`. Non-boundary elements are never stalled.

## Timing
- Reset values: `dout.valid`=0, `cnt_reg`=0, `ovf_reg`=0, output register data=0.
- Latency: closing element accepted in cycle N gives `dout.valid`=1 in cycle N+1.
- Throughput: 1 element/cycle. Back-to-back single-element groups sustain 1 count/cycle while `dout.ready`=1.
- `dout.valid` is driven only from the register and has no combinational path from din.
- `dout.data` stays stable while `dout.valid`=1 and `dout.ready`=0.
- `din.ready` has a combinational path from `dout.ready` and din eot only. There is no path from `din.valid` to `din.ready`.
- Reset mid-group: the partial count is discarded. The next accepted element starts a new group at 0.
- Reset with FULL: the pending output is dropped.
- `CNT_LVL`=`OUT_LVL`: every group counts as 1. `INCLUSIVE`=1 emits 1 and `INCLUSIVE`=0 emits 0.
- `OUT_LVL`=`DIN_LVL`: one count per top-level transaction.

## Structure
- Shared package `qlen_cnt_pkg`:
  - Typedef helpers for the din and dout structs, parameterised via localparam widths in the module.
  - Function `eot_all(eot, lvl)` returning the AND-reduce of the lowest `lvl` bits, with `lvl`=0 returning 1.
- One sub-module, `dti_out_reg`: the one-entry output buffer (valid/data register with load/unload) so it is reusable across cookbook blocks.
- Elaboration asserts `CNT_LVL`≤`OUT_LVL`≤`DIN_LVL`, `DIN_LVL`≥1 and `W_OUT`≥1.

## Test plan
- `DIN_LVL`=2, `CNT_LVL`=1, `OUT_LVL`=2, `INCLUSIVE`=1. Stimulus: eots 00,01,00,00,01,11, `dout.ready`=1. Response: one output `cnt`=3, `ovf`=0, valid the cycle after the 11 beat.
- Same stream with `INCLUSIVE`=0. Response: `cnt`=2.
- `DIN_LVL`=3, `CNT_LVL`=0, `OUT_LVL`=1, `TDIN`=8. Stimulus: groups of lengths 2, 1, 4 with outer eot 10, 10, 11. Response: outputs (cnt 2, eot 10), (cnt 1, eot 10), (cnt 4, eot 11).
- Backpressure. Stimulus: `dout.ready`=0 for 5 cycles while three single-element groups arrive. Response:
  - The first count is held stable.
  - The second boundary element sees `din.ready`=0 until `dout.ready` rises.
  - Counts arrive in order 1, 1, 1 with no loss.
- `W_OUT`=3, `CNT_LVL`=0. Stimulus: 10-element group.
  - `SATURATE`=1: `cnt`=7, `ovf`=1.
  - `SATURATE`=0: `cnt`=2, `ovf`=1.
  - The next 2-element group gives `cnt`=2, `ovf`=0.
- `rst` asserted for 1 cycle after 3 elements of an open group, and again while FULL. Response: `dout.valid`=0 next cycle, and the following 2-element group emits `cnt`=2.
